// File: rtl/btime_rom_loader.sv
// btime_rom_loader
//   Splits the linear HPS ROM download into four region-relative write streams
//   (program, tile, sprite, sound) and sequences the game core reset around a load.
//
// Ports
//   clk_sys         system clock (only clock)
//   reset           synchronous active-high reset
//   ioctl_download  high while the HPS transfer is active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      linear byte address
//   ioctl_dout      byte data
//   user_reset      OSD/button reset request (level)
//   dn_addr         region-relative byte address
//   dn_data         byte to write
//   dn_wr           one-cycle write strobe, one cycle after the accepted ioctl_wr
//   dn_cs           one-hot region select, valid with dn_wr
//   core_reset      game core reset, registered; low only in RUN
//   load_done       last load complete with exact size
//   load_err        last load short or overflowed, sticky until the next load
module btime_rom_loader #(
  parameter logic [16:0] R0_END      = 17'h0C000,
  parameter logic [16:0] R1_END      = 17'h12000,
  parameter logic [16:0] R2_END      = 17'h18000,
  parameter logic [16:0] R3_END      = 17'h1A000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  dn_cs,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

  localparam logic [17:0] Total = {1'b0, R3_END};

  state_e      state;
  logic [17:0] byte_cnt;
  logic [31:0] hold_cnt;

  // Region decode of the incoming address (strict less-than on each end).
  logic        in_range;
  logic [3:0]  cs_dec;
  logic [16:0] off_dec;

  always_comb begin
    in_range = (ioctl_addr < {8'd0, R3_END});
    cs_dec   = 4'b1000;
    off_dec  = ioctl_addr[16:0] - R2_END;
    if (ioctl_addr[16:0] < R0_END) begin
      cs_dec  = 4'b0001;
      off_dec = ioctl_addr[16:0];
    end else if (ioctl_addr[16:0] < R1_END) begin
      cs_dec  = 4'b0010;
      off_dec = ioctl_addr[16:0] - R0_END;
    end else if (ioctl_addr[16:0] < R2_END) begin
      cs_dec  = 4'b0100;
      off_dec = ioctl_addr[16:0] - R1_END;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= StIdle;
      core_reset <= 1'b1;
      dn_wr      <= 1'b0;
      dn_cs      <= 4'b0000;
      dn_addr    <= 17'd0;
      dn_data    <= 8'd0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_cnt   <= 18'd0;
      hold_cnt   <= 32'd0;
    end else begin
      dn_wr <= 1'b0;
      unique case (state)
        StIdle: begin
          core_reset <= 1'b1;
          if (ioctl_download) begin
            state     <= StLoad;
            byte_cnt  <= 18'd0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end

        StLoad: begin
          core_reset <= 1'b1;
          // A strobe in the cycle the download falls is still accepted.
          if (ioctl_wr) begin
            if (in_range) begin
              dn_wr   <= 1'b1;
              dn_cs   <= cs_dec;
              dn_addr <= off_dec;
              dn_data <= ioctl_dout;
              // Saturate so a runaway load can never wrap back to an exact size.
              if (byte_cnt != '1) begin
                byte_cnt <= byte_cnt + 18'd1;
              end
            end else begin
              load_err <= 1'b1;
            end
          end
          if (!ioctl_download) begin
            state    <= StHold;
            hold_cnt <= HOLD_CYCLES;
          end
        end

        StHold: begin
          core_reset <= 1'b1;
          if (ioctl_download) begin
            state     <= StLoad;
            byte_cnt  <= 18'd0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end else if (user_reset) begin
            // One extra count: the first cycle that sees user_reset low then
            // leaves exactly HOLD_CYCLES cycles before release.
            hold_cnt <= HOLD_CYCLES + 32'd1;
          end else if (hold_cnt <= 32'd1) begin
            state      <= StRun;
            core_reset <= 1'b0;
            if (byte_cnt == Total && !load_err) begin
              load_done <= 1'b1;
            end else begin
              load_done <= 1'b0;
              load_err  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end

        StRun: begin
          if (ioctl_download) begin
            state      <= StLoad;
            core_reset <= 1'b1;
            byte_cnt   <= 18'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end else if (user_reset) begin
            state      <= StHold;
            core_reset <= 1'b1;
            hold_cnt   <= HOLD_CYCLES + 32'd1;
          end else begin
            core_reset <= 1'b0;
          end
        end

        default: begin
          state      <= StIdle;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btime_rom_loader.sv
// Self-checking bench for btime_rom_loader. Uses a scaled-down region map so a
// complete image load stays short; boundaries keep the same shape as the default.
module tb_btime_rom_loader;

  localparam logic [16:0] R0   = 17'h000C0;
  localparam logic [16:0] R1   = 17'h00120;
  localparam logic [16:0] R2   = 17'h00180;
  localparam logic [16:0] R3   = 17'h001A0;
  localparam int unsigned HOLD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  dn_cs;
  logic        core_reset;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  // Reference model of the current load.
  int unsigned m_count;
  bit          m_err;

  always #5 clk = ~clk;

  btime_rom_loader #(
    .R0_END(R0), .R1_END(R1), .R2_END(R2), .R3_END(R3), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_reset(user_reset),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_cs(dn_cs),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err)
  );

  // Region map: walk the ends in order, first one strictly above the address wins.
  function automatic void ref_decode(input logic [24:0] a, output bit ok,
                                     output logic [3:0] cs, output logic [16:0] off);
    int unsigned ends [4];
    int unsigned base;
    ends = '{int'(R0), int'(R1), int'(R2), int'(R3)};
    base = 0;
    ok = 0; cs = 4'b0000; off = 17'd0;
    for (int r = 0; r < 4; r++) begin
      if (!ok && int'(a) < ends[r]) begin
        ok  = 1;
        cs  = 4'(1 << r);
        off = 17'(int'(a) - base);
      end
      base = ends[r];
    end
  endfunction

  function automatic bit ref_done();
    return (m_count == int'(R3)) && !m_err;
  endfunction

  task automatic start_load();
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    m_count = 0;
    m_err   = 0;
  endtask

  // Strobe one byte (optionally dropping download in the same cycle) and
  // capture the outputs one cycle later.
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit drop,
                            output logic o_wr, output logic [3:0] o_cs,
                            output logic [16:0] o_addr, output logic [7:0] o_data);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    o_wr = dn_wr; o_cs = dn_cs; o_addr = dn_addr; o_data = dn_data;
  endtask

  // Bounded wait for core_reset to fall; returns the edge count, 0 if never.
  task automatic wait_release(output int edges);
    edges = 0;
    for (int k = 1; k <= int'(HOLD) + 40; k++) begin
      @(posedge clk); #1;
      if (core_reset === 1'b0) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic model_write(input logic [24:0] a, input logic [7:0] d, input bit drop,
                             input string name);
    bit ok; logic [3:0] cs; logic [16:0] off;
    logic o_wr; logic [3:0] o_cs; logic [16:0] o_addr; logic [7:0] o_data;
    ref_decode(a, ok, cs, off);
    write_byte(a, d, drop, o_wr, o_cs, o_addr, o_data);
    checks++;
    if (o_wr !== ok || (ok && {o_cs, o_addr, o_data} !== {cs, off, d})) begin
      errors++;
      $display("FAIL %s a=%h: got wr=%b cs=%b addr=%h data=%h, want wr=%b cs=%b addr=%h data=%h",
               name, a, o_wr, o_cs, o_addr, o_data, ok, cs, off, d);
    end
    if (ok) m_count++;
    else m_err = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({core_reset, dn_wr, dn_cs, dn_addr, dn_data, load_done, load_err} !==
        {1'b1, 1'b0, 4'b0, 17'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got core=%b wr=%b cs=%b addr=%h data=%h done=%b err=%b",
               core_reset, dn_wr, dn_cs, dn_addr, dn_data, load_done, load_err);
    end
    reset = 1'b0; ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    checks++;
    if (dn_wr !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL idle_ignore_wr: got wr=%b core=%b, want wr=0 core=1", dn_wr, core_reset);
    end
  endtask

  task automatic test_full_load();
    int edges;
    logic o_wr; logic [3:0] o_cs; logic [16:0] o_addr; logic [7:0] o_data;
    start_load();
    for (int a = 0; a < int'(R3); a++) begin
      if (a == int'(R0)) begin
        write_byte(25'(a), 8'($urandom), 1'b0, o_wr, o_cs, o_addr, o_data);
        m_count++;
        checks++;
        if ({o_wr, o_cs, o_addr} !== {1'b1, 4'b0010, 17'd0}) begin
          errors++;
          $display("FAIL r0_boundary: got wr=%b cs=%b addr=%h, want wr=1 cs=0010 addr=0",
                   o_wr, o_cs, o_addr);
        end
      end else begin
        model_write(25'(a), 8'($urandom), 1'b0, "full_load");
      end
    end
    ioctl_download = 1'b0;
    wait_release(edges);
    checks++;
    if (edges != int'(HOLD) + 1) begin
      errors++;
      $display("FAIL full_release: core_reset fell at edge %0d, want %0d", edges, HOLD + 1);
    end
    checks++;
    if (load_done !== ref_done() || load_err !== m_err) begin
      errors++;
      $display("FAIL full_status: got done=%b err=%b, want done=%b err=%b",
               load_done, load_err, ref_done(), m_err);
    end
  endtask

  task automatic test_user_reset();
    bit exp;
    checks++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL user_pre_run: got core=%b, want 0", core_reset);
    end
    for (int k = 1; k <= int'(HOLD) + 8; k++) begin
      user_reset = (k <= 5);
      ioctl_wr   = (k == 3);
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      exp = (k <= int'(HOLD) + 5);
      checks++;
      if (core_reset !== exp || dn_wr !== 1'b0) begin
        errors++;
        $display("FAIL user_reset k=%0d: got core=%b wr=%b, want core=%b wr=0",
                 k, core_reset, dn_wr, exp);
      end
    end
    user_reset = 1'b0;
  endtask

  task automatic test_short_load();
    int edges;
    start_load();
    for (int a = 0; a < 'h40; a++) model_write(25'(a), 8'($urandom), 1'b0, "short_load");
    ioctl_download = 1'b0;
    wait_release(edges);
    checks++;
    if (edges != int'(HOLD) + 1 || load_err !== 1'b1 || load_done !== 1'b0 ||
        ref_done() || !(m_count != int'(R3))) begin
      errors++;
      $display("FAIL short_load: got edge=%0d done=%b err=%b, want edge=%0d done=0 err=1",
               edges, load_done, load_err, HOLD + 1);
    end
  endtask

  task automatic test_out_of_range();
    int edges;
    logic [24:0] a;
    start_load();
    model_write({8'd0, R3}, 8'hA5, 1'b0, "oor_total");
    model_write(25'h0020000, 8'h5A, 1'b0, "oor_20000");
    model_write(25'h1000005, 8'h3C, 1'b0, "oor_high_bits");
    for (int i = 0; i < 40; i++) begin
      a = 25'($urandom_range(0, int'(R3) + 'h40));
      model_write(a, 8'($urandom), 1'b0, "rand_write");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        checks++;
        if (dn_wr !== 1'b0) begin
          errors++;
          $display("FAIL gap_no_wr: got wr=%b, want 0", dn_wr);
        end
      end
    end
    ioctl_download = 1'b0;
    wait_release(edges);
    checks++;
    if (edges != int'(HOLD) + 1 || load_err !== 1'b1 || load_done !== ref_done()) begin
      errors++;
      $display("FAIL oor_status: got edge=%0d done=%b err=%b, want edge=%0d done=%b err=1",
               edges, load_done, load_err, HOLD + 1, ref_done());
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    start_load();
    for (int a = 0; a < 5; a++) model_write(25'(a), 8'($urandom), 1'b0, "b2b_pre");
    model_write({8'd0, R3} + 25'd2, 8'h11, 1'b0, "b2b_oor");
    model_write({8'd0, R1}, 8'h77, 1'b1, "b2b_drop_wr");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (core_reset !== 1'b1 || dn_wr !== 1'b0 || load_err !== 1'b1) begin
        errors++;
        $display("FAIL b2b_hold k=%0d: got core=%b wr=%b err=%b, want core=1 wr=0 err=1",
                 k, core_reset, dn_wr, load_err);
      end
    end
    start_load();
    checks++;
    if (core_reset !== 1'b1 || load_err !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload: got core=%b done=%b err=%b, want core=1 done=0 err=0",
               core_reset, load_done, load_err);
    end
    for (int a = 0; a < int'(R3); a++) begin
      model_write(25'(a), 8'($urandom), a == int'(R3) - 1, "b2b_full");
    end
    // The final write's edge already saw download low.
    wait_release(edges);
    checks++;
    if (edges != int'(HOLD) || load_done !== ref_done() || load_err !== m_err) begin
      errors++;
      $display("FAIL b2b_status: got edge=%0d done=%b err=%b, want edge=%0d done=%b err=%b",
               edges, load_done, load_err, HOLD, ref_done(), m_err);
    end
  endtask

  task automatic test_reset_mid_load();
    bit saw_low;
    start_load();
    ioctl_wr = 1'b1; ioctl_addr = 25'h3; ioctl_dout = 8'hC3;
    @(posedge clk); #1;
    ioctl_wr = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dn_wr, core_reset, dn_cs, dn_addr, dn_data, load_done, load_err} !==
        {1'b0, 1'b1, 4'b0, 17'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_load_reset: got wr=%b core=%b cs=%b addr=%h data=%h done=%b err=%b",
               dn_wr, core_reset, dn_cs, dn_addr, dn_data, load_done, load_err);
    end
    reset = 1'b0; ioctl_download = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h5;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dn_wr !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset_wr: got wr=%b, want 0", dn_wr);
    end
    saw_low = 0;
    repeat (HOLD + 8) begin
      @(posedge clk); #1;
      if (core_reset !== 1'b1) saw_low = 1;
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL idle_holds_core: got core_reset low while idle, want 1");
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_user_reset();
    test_short_load();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
